// File: rtl/trigger_arm_sequencer.sv
// Purpose : arms the comparator trigger block, then gates post-trigger capture, clears the latch and reports completion.
// Latency : armed/capture_en/busy one clock after an accepted arm_req; done after post_count + RESET_CYCLES + 2 clocks from trigger rise.
// Backpr. : none; arm_req is single-cycle and dropped while busy, with no queue. WAIT_CLR holds until triggered drops.
//
// Ports:
//   clk_i, reset_n_i       clock; synchronous active-low reset
//   arm_req_i, abort_i     start request (IDLE only) and abort level
//   post_count_i           post-trigger capture length, latched on arm
//   triggered_i            comparator-fired flag from the trigger block
//   armed_o, t_reset_o     handshake outputs to the trigger block
//   capture_en_o           sample-buffer write enable
//   trig_mark_o            first post-trigger capture cycle marker
//   busy_o, done_o, aborted_o, acq_count_o   status to command/readout logic
module trigger_arm_sequencer #(
    parameter int CNT_W        = 16,
    parameter int RESET_CYCLES = 5
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             arm_req_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] post_count_i,
    input  logic             triggered_i,
    output logic             armed_o,
    output logic             t_reset_o,
    output logic             capture_en_o,
    output logic             trig_mark_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [15:0]      acq_count_o
);

    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RESET_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_CLEAR, S_WAIT_CLR, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_lim_q, cnt_lim_d;
    logic [CNT_W-1:0]   cap_cnt_q, cap_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic               abort_flag_q, abort_flag_d;
    logic               armed_d, t_reset_d, capture_en_d, trig_mark_d;
    logic               busy_d, done_d, aborted_d;
    logic [15:0]        acq_count_d;
    logic               go_clear;

    always_comb begin
        state_d      = state_q;
        cnt_lim_d    = cnt_lim_q;
        cap_cnt_d    = cap_cnt_q;
        rst_cnt_d    = rst_cnt_q;
        abort_flag_d = abort_flag_q;
        armed_d      = armed_o;
        t_reset_d    = t_reset_o;
        capture_en_d = capture_en_o;
        trig_mark_d  = 1'b0;
        busy_d       = busy_o;
        done_d       = 1'b0;
        aborted_d    = 1'b0;
        acq_count_d  = acq_count_o;
        go_clear     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (arm_req_i) begin
                    state_d      = S_ARM;
                    cnt_lim_d    = post_count_i;
                    armed_d      = 1'b1;
                    capture_en_d = 1'b1;   // pre-trigger fill starts immediately
                    busy_d       = 1'b1;
                end
            end
            S_ARM: begin
                // abort wins over a simultaneous trigger
                if (abort_i) begin
                    abort_flag_d = 1'b1;
                    go_clear     = 1'b1;
                end else if (triggered_i) begin
                    if (cnt_lim_q == '0) begin
                        go_clear = 1'b1;
                    end else begin
                        state_d     = S_CAPTURE;
                        armed_d     = 1'b0;
                        trig_mark_d = 1'b1;
                        cap_cnt_d   = CNT_W'(1);
                    end
                end
            end
            S_CAPTURE: begin
                if (abort_i) begin
                    abort_flag_d = 1'b1;
                    go_clear     = 1'b1;
                end else if (cap_cnt_q == cnt_lim_q) begin
                    // equality test, so an all-ones limit never needs the counter to wrap
                    go_clear = 1'b1;
                end else begin
                    cap_cnt_d = cap_cnt_q + CNT_W'(1);
                end
            end
            S_CLEAR: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = S_WAIT_CLR;
                    t_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_CLR: begin
                if (!triggered_i) begin
                    state_d = S_FINISH;
                    if (abort_flag_q) begin
                        aborted_d = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                        acq_count_d = acq_count_o + 16'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d      = S_IDLE;
                abort_flag_d = 1'b0;
                busy_d       = 1'b0;
                cap_cnt_d    = '0;
                rst_cnt_d    = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // common entry into CLEAR: stop capture, start the latch-clear pulse
        if (go_clear) begin
            state_d      = S_CLEAR;
            armed_d      = 1'b0;
            capture_en_d = 1'b0;
            t_reset_d    = 1'b1;
            rst_cnt_d    = RST_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            cnt_lim_q    <= '0;
            cap_cnt_q    <= '0;
            rst_cnt_q    <= '0;
            abort_flag_q <= 1'b0;
            armed_o      <= 1'b0;
            t_reset_o    <= 1'b0;
            capture_en_o <= 1'b0;
            trig_mark_o  <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            aborted_o    <= 1'b0;
            acq_count_o  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_lim_q    <= cnt_lim_d;
            cap_cnt_q    <= cap_cnt_d;
            rst_cnt_q    <= rst_cnt_d;
            abort_flag_q <= abort_flag_d;
            armed_o      <= armed_d;
            t_reset_o    <= t_reset_d;
            capture_en_o <= capture_en_d;
            trig_mark_o  <= trig_mark_d;
            busy_o       <= busy_d;
            done_o       <= done_d;
            aborted_o    <= aborted_d;
            acq_count_o  <= acq_count_d;
        end
    end

endmodule
